// File: rtl/qdr2p_port_arbiter_if.sv
// Requester and controller-side bundle for the QDR-II+ port arbiter.
// The arbiter takes the slave view; the environment or requesters take the master view.
interface qdr2p_port_arbiter_if #(
  parameter int NUM_PORTS       = 4,
  parameter int ADDR_BITS       = 18,
  parameter int DATA_WIDTH      = 144,
  parameter int MAX_OUTSTANDING = 16
);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  logic [NUM_PORTS-1:0]            port_rd_req;
  logic [NUM_PORTS*ADDR_BITS-1:0]  port_rd_addr;
  logic [NUM_PORTS-1:0]            port_rd_ack;
  logic [NUM_PORTS-1:0]            port_wr_req;
  logic [NUM_PORTS*ADDR_BITS-1:0]  port_wr_addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0] port_wr_data;
  logic [NUM_PORTS-1:0]            port_wr_ack;
  logic [NUM_PORTS-1:0]            port_rd_valid;
  logic [DATA_WIDTH-1:0]           port_rd_data;
  logic                            ctl_rd_en;
  logic [ADDR_BITS-1:0]            ctl_rd_addr;
  logic                            ctl_wr_en;
  logic [ADDR_BITS-1:0]            ctl_wr_addr;
  logic [DATA_WIDTH-1:0]           ctl_wr_data;
  logic                            ctl_rd_valid;
  logic [DATA_WIDTH-1:0]           ctl_rd_data;
  logic [CW-1:0]                   rd_outstanding;
  logic                            rd_underflow;

  modport slave (
    input  port_rd_req, port_rd_addr, port_wr_req, port_wr_addr, port_wr_data,
           ctl_rd_valid, ctl_rd_data,
    output port_rd_ack, port_wr_ack, port_rd_valid, port_rd_data,
           ctl_rd_en, ctl_rd_addr, ctl_wr_en, ctl_wr_addr, ctl_wr_data,
           rd_outstanding, rd_underflow
  );

  modport master (
    output port_rd_req, port_rd_addr, port_wr_req, port_wr_addr, port_wr_data,
           ctl_rd_valid, ctl_rd_data,
    input  port_rd_ack, port_wr_ack, port_rd_valid, port_rd_data,
           ctl_rd_en, ctl_rd_addr, ctl_wr_en, ctl_wr_addr, ctl_wr_data,
           rd_outstanding, rd_underflow
  );
endinterface

// File: rtl/qdr2p_port_arbiter.sv
// Round-robin read/write arbiter sharing one QDR-II+ controller; acks combinational, issue and return 1 clk.
// Reads stall once MAX_OUTSTANDING are in flight; writes are never held off; a tag FIFO steers read returns.
module qdr2p_port_arbiter #(
  parameter int NUM_PORTS       = 4,
  parameter int ADDR_BITS       = 18,
  parameter int DATA_WIDTH      = 144,
  parameter int MAX_OUTSTANDING = 16
) (
  input logic                clk,
  input logic                rst_n,
  qdr2p_port_arbiter_if.slave bus
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int TW = $clog2(MAX_OUTSTANDING);
  localparam int CW = TW + 1;

  logic [PW-1:0]         r_rd_ptr, r_wr_ptr;
  logic                  w_rd_gnt, w_wr_gnt;
  logic [PW-1:0]         w_rd_idx, w_wr_idx;
  logic [NUM_PORTS-1:0]  w_rd_ack, w_wr_ack;
  logic                  w_rd_allow;
  logic                  w_pop;
  logic [NUM_PORTS-1:0]  w_ret_onehot;

  logic [PW-1:0]         r_tag_mem [MAX_OUTSTANDING];
  logic [TW-1:0]         r_tag_wptr, r_tag_rptr;
  logic [CW-1:0]         r_rd_cnt;

  logic                  r_ctl_rd_en, r_ctl_wr_en;
  logic [ADDR_BITS-1:0]  r_ctl_rd_addr, r_ctl_wr_addr;
  logic [DATA_WIDTH-1:0] r_ctl_wr_data;
  logic [NUM_PORTS-1:0]  r_port_rd_valid;
  logic [DATA_WIDTH-1:0] r_port_rd_data;
  logic                  r_rd_underflow;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] ptr, input int k);
    int s;
    s = int'(ptr) + k;
    if (s >= NUM_PORTS) s = s - NUM_PORTS;
    return PW'(s);
  endfunction

  // Conservative throttle: a same-cycle return does not free a slot until the next cycle.
  assign w_rd_allow = (r_rd_cnt != CW'(MAX_OUTSTANDING));
  assign w_pop      = bus.ctl_rd_valid && (r_rd_cnt != '0);

  always_comb begin
    w_rd_gnt = 1'b0;
    w_rd_idx = r_rd_ptr;
    w_wr_gnt = 1'b0;
    w_wr_idx = r_wr_ptr;
    w_rd_ack = '0;
    w_wr_ack = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      if (!w_rd_gnt && w_rd_allow && bus.port_rd_req[f_next(r_rd_ptr, k)]) begin
        w_rd_gnt = 1'b1;
        w_rd_idx = f_next(r_rd_ptr, k);
      end
      if (!w_wr_gnt && bus.port_wr_req[f_next(r_wr_ptr, k)]) begin
        w_wr_gnt = 1'b1;
        w_wr_idx = f_next(r_wr_ptr, k);
      end
    end
    if (w_rd_gnt) w_rd_ack[w_rd_idx] = 1'b1;
    if (w_wr_gnt) w_wr_ack[w_wr_idx] = 1'b1;
  end

  always_comb begin
    w_ret_onehot = '0;
    w_ret_onehot[r_tag_mem[r_tag_rptr]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_rd_gnt) r_tag_mem[r_tag_wptr] <= w_rd_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr        <= PW'(NUM_PORTS - 1);
      r_wr_ptr        <= PW'(NUM_PORTS - 1);
      r_tag_wptr      <= '0;
      r_tag_rptr      <= '0;
      r_rd_cnt        <= '0;
      r_ctl_rd_en     <= 1'b0;
      r_ctl_rd_addr   <= '0;
      r_ctl_wr_en     <= 1'b0;
      r_ctl_wr_addr   <= '0;
      r_ctl_wr_data   <= '0;
      r_port_rd_valid <= '0;
      r_port_rd_data  <= '0;
      r_rd_underflow  <= 1'b0;
    end else begin
      if (w_rd_gnt) r_rd_ptr <= w_rd_idx;
      if (w_wr_gnt) r_wr_ptr <= w_wr_idx;

      // Idle cycles drive zeros onto the controller buses to limit toggling.
      r_ctl_rd_en   <= w_rd_gnt;
      r_ctl_rd_addr <= w_rd_gnt ? bus.port_rd_addr[int'(w_rd_idx)*ADDR_BITS +: ADDR_BITS] : '0;
      r_ctl_wr_en   <= w_wr_gnt;
      r_ctl_wr_addr <= w_wr_gnt ? bus.port_wr_addr[int'(w_wr_idx)*ADDR_BITS +: ADDR_BITS] : '0;
      r_ctl_wr_data <= w_wr_gnt ? bus.port_wr_data[int'(w_wr_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;

      if (w_rd_gnt) r_tag_wptr <= r_tag_wptr + 1'b1;
      if (w_pop)    r_tag_rptr <= r_tag_rptr + 1'b1;
      if (w_rd_gnt && !w_pop)      r_rd_cnt <= r_rd_cnt + 1'b1;
      else if (!w_rd_gnt && w_pop) r_rd_cnt <= r_rd_cnt - 1'b1;

      r_port_rd_valid <= w_pop ? w_ret_onehot : '0;
      if (w_pop) r_port_rd_data <= bus.ctl_rd_data;
      if (bus.ctl_rd_valid && (r_rd_cnt == '0)) r_rd_underflow <= 1'b1;
    end
  end

  assign bus.port_rd_ack    = w_rd_ack;
  assign bus.port_wr_ack    = w_wr_ack;
  assign bus.ctl_rd_en      = r_ctl_rd_en;
  assign bus.ctl_rd_addr    = r_ctl_rd_addr;
  assign bus.ctl_wr_en      = r_ctl_wr_en;
  assign bus.ctl_wr_addr    = r_ctl_wr_addr;
  assign bus.ctl_wr_data    = r_ctl_wr_data;
  assign bus.port_rd_valid  = r_port_rd_valid;
  assign bus.port_rd_data   = r_port_rd_data;
  assign bus.rd_outstanding = r_rd_cnt;
  assign bus.rd_underflow   = r_rd_underflow;
endmodule

// File: tb/tb_qdr2p_port_arbiter.sv
// Directed bench for qdr2p_port_arbiter; stimulus pushes expected issues/returns, a monitor pops and compares.
module tb_qdr2p_port_arbiter;
  localparam int NP = 4;
  localparam int AB = 18;
  localparam int DW = 144;
  localparam int MO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qdr2p_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_BITS(AB), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) bus ();

  qdr2p_port_arbiter #(.NUM_PORTS(NP), .ADDR_BITS(AB), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [AB-1:0] q_rd_addr [$];
  logic [AB-1:0] q_wr_addr [$];
  logic [DW-1:0] q_wr_data [$];
  logic [NP-1:0] q_ret_port [$];
  logic [DW-1:0] q_ret_data [$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] wdat(input int p);
    logic [7:0] b;
    b = 8'(8'hA0 + p);
    return {18{b}};
  endfunction

  function automatic logic [DW-1:0] rdat(input int n);
    logic [15:0] h;
    h = 16'(16'hC000 + n);
    return {9{h}};
  endfunction

  function automatic logic [AB-1:0] raddr(input int p);
    return AB'(32'h100 + p);
  endfunction

  function automatic logic [AB-1:0] waddr(input int p);
    return AB'(32'h200 + p);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single requester read grant; exp_ack is the hand-derived one-hot.
  task automatic rd_grant(input int p, input logic [NP-1:0] exp_ack);
    bus.port_rd_req = bus.port_rd_req | (NP'(1) << p);
    @(negedge clk);
    chk("rd_ack", bus.port_rd_ack, exp_ack);
    q_rd_addr.push_back(raddr(p));
    tick();
    bus.port_rd_req = '0;
  endtask

  // One controller return; exp_port == 0 means no pop is expected.
  task automatic ret(input logic [DW-1:0] d, input logic [NP-1:0] exp_port);
    bus.ctl_rd_valid = 1'b1;
    bus.ctl_rd_data  = d;
    if (exp_port != '0) begin
      q_ret_port.push_back(exp_port);
      q_ret_data.push_back(d);
    end
    tick();
    bus.ctl_rd_valid = 1'b0;
    @(negedge clk);
    chk("ret_strobe", bus.port_rd_valid, exp_port);
    tick();
  endtask

  // Monitor: compare every controller issue and every port return against the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.ctl_rd_en) begin
          if (q_rd_addr.size() == 0) begin
            tests++; fails++;
            $display("FAIL rd_issue: unexpected ctl_rd_en addr %0h, expected none", bus.ctl_rd_addr);
          end else chk("rd_issue_addr", bus.ctl_rd_addr, q_rd_addr.pop_front());
        end else chk("rd_idle_addr", bus.ctl_rd_addr, '0);
        if (bus.ctl_wr_en) begin
          if (q_wr_addr.size() == 0) begin
            tests++; fails++;
            $display("FAIL wr_issue: unexpected ctl_wr_en addr %0h, expected none", bus.ctl_wr_addr);
          end else begin
            chk("wr_issue_addr", bus.ctl_wr_addr, q_wr_addr.pop_front());
            chk("wr_issue_data", bus.ctl_wr_data, q_wr_data.pop_front());
          end
        end else chk("wr_idle_data", bus.ctl_wr_data, '0);
        if (bus.port_rd_valid != '0) begin
          if (q_ret_port.size() == 0) begin
            tests++; fails++;
            $display("FAIL rd_return: unexpected port_rd_valid %0h, expected none", bus.port_rd_valid);
          end else begin
            chk("ret_port", bus.port_rd_valid, q_ret_port.pop_front());
            chk("ret_data", bus.port_rd_data, q_ret_data.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.port_rd_req  = '0;
    bus.port_wr_req  = '0;
    bus.ctl_rd_valid = 1'b0;
    bus.ctl_rd_data  = '0;
    for (int i = 0; i < NP; i++) begin
      bus.port_rd_addr[i*AB +: AB] = raddr(i);
      bus.port_wr_addr[i*AB +: AB] = waddr(i);
      bus.port_wr_data[i*DW +: DW] = wdat(i);
    end

    // Reset state
    #12;
    chk("rst_ctl_rd_en", bus.ctl_rd_en, '0);
    chk("rst_ctl_wr_en", bus.ctl_wr_en, '0);
    chk("rst_rd_valid", bus.port_rd_valid, '0);
    chk("rst_rd_data", bus.port_rd_data, '0);
    chk("rst_outstanding", bus.rd_outstanding, '0);
    chk("rst_underflow", bus.rd_underflow, '0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: all ports request reads -> 0,1,2,3,0,1,2,3
    bus.port_rd_req = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_rd_ack", bus.port_rd_ack, NP'(1) << (k % NP));
      q_rd_addr.push_back(raddr(k % NP));
      tick();
    end
    bus.port_rd_req = '0;
    @(negedge clk);
    chk("rr_outstanding", bus.rd_outstanding, 5'd8);
    tick();
    for (int n = 0; n < 8; n++) ret(rdat(n), NP'(1) << (n % NP));

    // 1b: write round robin, independent pointer
    bus.port_wr_req = '1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rr_wr_ack", bus.port_wr_ack, NP'(1) << (k % NP));
      q_wr_addr.push_back(waddr(k % NP));
      q_wr_data.push_back(wdat(k % NP));
      tick();
    end
    bus.port_wr_req = '0;
    tick();

    // 2: simultaneous read (port 2) and write (port 1)
    bus.port_rd_req = 4'b0100;
    bus.port_wr_req = 4'b0010;
    @(negedge clk);
    chk("dual_rd_ack", bus.port_rd_ack, 4'b0100);
    chk("dual_wr_ack", bus.port_wr_ack, 4'b0010);
    q_rd_addr.push_back(raddr(2));
    q_wr_addr.push_back(waddr(1));
    q_wr_data.push_back(wdat(1));
    tick();
    bus.port_rd_req = '0;
    bus.port_wr_req = '0;
    @(negedge clk);
    chk("dual_rd_en", bus.ctl_rd_en, 1'b1);
    chk("dual_wr_en", bus.ctl_wr_en, 1'b1);
    tick();
    ret(rdat(20), 4'b0100);

    // 3: throttle at MAX_OUTSTANDING
    bus.port_rd_req = 4'b0001;
    for (int g = 0; g < MO; g++) begin
      @(negedge clk);
      chk("fill_ack", bus.port_rd_ack, 4'b0001);
      q_rd_addr.push_back(raddr(0));
      tick();
    end
    @(negedge clk);
    chk("full_outstanding", bus.rd_outstanding, 5'd16);
    chk("full_ack_blocked", bus.port_rd_ack, '0);
    tick();
    bus.ctl_rd_valid = 1'b1;
    bus.ctl_rd_data  = rdat(30);
    q_ret_port.push_back(4'b0001);
    q_ret_data.push_back(rdat(30));
    @(negedge clk);
    chk("full_ack_same_pop", bus.port_rd_ack, '0);
    tick();
    bus.ctl_rd_valid = 1'b0;
    @(negedge clk);
    chk("full_ack_release", bus.port_rd_ack, 4'b0001);
    chk("full_ret_strobe", bus.port_rd_valid, 4'b0001);
    q_rd_addr.push_back(raddr(0));
    tick();
    bus.port_rd_req = '0;
    for (int n = 0; n < MO; n++) ret(rdat(31 + n), 4'b0001);
    @(negedge clk);
    chk("drained_outstanding", bus.rd_outstanding, '0);
    tick();

    // 4: tag steering 3,0,3
    rd_grant(3, 4'b1000);
    rd_grant(0, 4'b0001);
    rd_grant(3, 4'b1000);
    ret(rdat(60), 4'b1000);
    ret(rdat(61), 4'b0001);
    ret(rdat(62), 4'b1000);

    // 5: underflow
    @(negedge clk);
    chk("pre_uf_flag", bus.rd_underflow, 1'b0);
    tick();
    ret(rdat(99), '0);
    chk("uf_flag", bus.rd_underflow, 1'b1);
    chk("uf_data_hold", bus.port_rd_data, rdat(62));
    tick();
    tick();
    chk("uf_sticky", bus.rd_underflow, 1'b1);

    // 6: reset with 5 reads in flight
    for (int k = 0; k < 5; k++) rd_grant(1, 4'b0010);
    @(negedge clk);
    chk("mid_outstanding", bus.rd_outstanding, 5'd5);
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_ctl_rd_en", bus.ctl_rd_en, '0);
    chk("arst_ctl_wr_en", bus.ctl_wr_en, '0);
    chk("arst_ctl_rd_addr", bus.ctl_rd_addr, '0);
    chk("arst_ctl_wr_data", bus.ctl_wr_data, '0);
    chk("arst_rd_valid", bus.port_rd_valid, '0);
    chk("arst_rd_data", bus.port_rd_data, '0);
    chk("arst_outstanding", bus.rd_outstanding, '0);
    chk("arst_underflow", bus.rd_underflow, '0);
    tick();
    rst_n = 1'b1;
    tick();
    bus.port_rd_req = '1;
    bus.port_wr_req = '1;
    @(negedge clk);
    chk("post_rst_rd_ack", bus.port_rd_ack, 4'b0001);
    chk("post_rst_wr_ack", bus.port_wr_ack, 4'b0001);
    q_rd_addr.push_back(raddr(0));
    q_wr_addr.push_back(waddr(0));
    q_wr_data.push_back(wdat(0));
    tick();
    bus.port_rd_req = '0;
    bus.port_wr_req = '0;
    tick();
    // One read is legitimately outstanding; its return is genuine, the second is a late one.
    ret(rdat(70), 4'b0001);
    ret(rdat(71), '0);
    chk("late_ret_underflow", bus.rd_underflow, 1'b1);

    tick();
    tick();
    chk("rd_q_empty", q_rd_addr.size(), '0);
    chk("wr_q_empty", q_wr_addr.size(), '0);
    chk("ret_q_empty", q_ret_port.size(), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
